// File: rtl/serial_rx_deserializer.sv
// LSB-first framed serial receiver (start 0, DATA_WIDTH bits, stop 1) with a 2-flop input synchronizer.
// Latency: valid one cycle after the stop mid-sample; no backpressure, each word is a one-cycle strobe.
module serial_rx_deserializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  framing_error,
  output logic                  busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int IW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    BREAK,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, next_state;

  logic                  sync1, sync2;
  logic [1:0]            sync_fill;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH:0]   shift_ext;
  logic                  tick;
  logic                  line_high;
  logic                  stop_ok;
  logic                  stop_bad;

  // sync2 carries reset-value ones for two edges; only trust it as "line high" once real samples arrive
  assign line_high = sync_fill[1] & sync2;
  assign shift_ext = {sync2, shift_reg};

  always_comb begin
    tick = 1'b0;
    case (state)
      START:      tick = (cnt == HALF_LAST);
      DATA, STOP: tick = (cnt == BIT_LAST);
      default:    tick = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= BREAK;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      BREAK: if (line_high) next_state = IDLE;
      IDLE:  if (!sync2) next_state = START;
      START: if (tick) next_state = sync2 ? IDLE : DATA;
      DATA:  if (tick && (bit_idx == IDX_LAST)) next_state = STOP;
      STOP:  if (tick) next_state = sync2 ? IDLE : BREAK;
      default: next_state = BREAK;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    stop_ok  = (state == STOP) && tick && sync2;
    stop_bad = (state == STOP) && tick && !sync2;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      sync_fill     <= 2'b00;
      cnt           <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      data_out      <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      sync1         <= serial_in;
      sync2         <= sync1;
      sync_fill     <= {sync_fill[0], 1'b1};
      valid         <= stop_ok;
      framing_error <= stop_bad;

      if ((state == START) || (state == DATA) || (state == STOP)) begin
        if (tick) cnt <= '0;
        else      cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end

      if ((state == START) && tick) bit_idx <= '0;
      if ((state == DATA) && tick) begin
        bit_idx   <= bit_idx + IW'(1);
        shift_reg <= shift_ext[DATA_WIDTH:1];
      end

      if (stop_ok) data_out <= shift_reg;
    end
  end

endmodule
